id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/mips_pipe_pkg.sv | 65 ++++++
 rtl/id_ex_pipe_hazard_unit.sv | 26 ++
 rtl/id_ex_pipe.sv | 124 ++++++++++++
 tb/tb_id_ex_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline control bundle, ALUOp encodings and opcodes
package mips_pipe_pkg;

  localparam int CTRL_W = 11;

  // Bit offsets of the control bundle, MSB first in the order the decoder emits them.
  localparam int CTRL_REG_DST    = 10;
  localparam int CTRL_ALU_SRC    = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 3;
  localparam int CTRL_EXTEND_SEL = 2;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       extend_sel;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_MADD  = 2'd3
  } aluop_t;

  typedef enum logic [5:0] {
    OP_R_FORMAT = 6'd0,
    OP_J        = 6'd2,
    OP_BEQ      = 6'd4,
    OP_ADDIU    = 6'd9,
    OP_MADDU    = 6'd28,
    OP_LW       = 6'd35,
    OP_SW       = 6'd43
  } opcode_t;

  function automatic ctrl_t decode_ctrl(opcode_t op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R_FORMAT: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_FUNCT; end
      OP_J:        c.jump = 1'b1;
      OP_BEQ:      begin c.branch = 1'b1; c.alu_op = ALUOP_SUB; end
      OP_ADDIU:    begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.extend_sel = 1'b1; end
      OP_MADDU:    begin c.reg_dst = 1'b1; c.alu_op = ALUOP_MADD; end
      OP_LW:       begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                         c.mem_read = 1'b1; c.extend_sel = 1'b1; end
      OP_SW:       begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.extend_sel = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_unit.sv
// rtl/id_ex_pipe_hazard_unit.sv - combinational load-use hazard detection between EX and ID
module hazard_unit (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       id_valid_i,
  input  logic       id_jump_i,
  input  logic       id_reg_dst_i,
  input  logic       id_branch_i,
  input  logic       id_mem_write_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       load_use_o
);

  logic use_rs;
  logic use_rt;

  // J carries junk in its rs field; only R-type, branches and stores actually read rt.
  assign use_rs = ~id_jump_i;
  assign use_rt = id_reg_dst_i | id_branch_i | id_mem_write_i;

  assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != 5'd0) & id_valid_i &
                      ((use_rs & (ex_rt_i == id_rs_i)) | (use_rt & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall and flush bubbles;
// ID_EX_PERF_EN adds a saturating inserted-bubble counter
module id_ex_pipe
  import mips_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [5:0]        ex_funct,
  output logic              stall,
  output logic              en_reg
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [31:0]       ex_pc4_q, ex_rs_data_q, ex_rt_data_q, ex_imm_q;
  logic [4:0]        ex_rs_q, ex_rt_q, ex_rd_q;
  logic [5:0]        ex_funct_q;
  logic              load_use;
  logic              bubble;

  hazard_unit u_hazard (
    .ex_valid_i     (ex_valid_q),
    .ex_mem_read_i  (ex_ctrl_q[CTRL_MEM_READ]),
    .ex_rt_i        (ex_rt_q),
    .id_valid_i     (id_valid),
    .id_jump_i      (id_ctrl[CTRL_JUMP]),
    .id_reg_dst_i   (id_ctrl[CTRL_REG_DST]),
    .id_branch_i    (id_ctrl[CTRL_BRANCH]),
    .id_mem_write_i (id_ctrl[CTRL_MEM_WRITE]),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .load_use_o     (load_use)
  );

  // Masking with rst keeps the decoder enabled while the pipe is being cleared.
  assign stall  = load_use & ~rst;
  assign en_reg = ~stall;
  assign bubble = stall | flush | ~id_valid;

  always_comb begin
    ex_valid_d = ~bubble;
    ex_ctrl_d  = bubble ? '0 : id_ctrl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_funct_q   <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= id_pc4;
      ex_rs_data_q <= id_rs_data;
      ex_rt_data_q <= id_rt_data;
      ex_imm_q     <= id_imm;
      ex_rs_q      <= id_rs;
      ex_rt_q      <= id_rt;
      ex_rd_q      <= id_rd;
      ex_funct_q   <= id_funct;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_pc4     = ex_pc4_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_funct   = ex_funct_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Idle slots (id_valid=0) are not hazards, so they are not counted.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((stall | flush) && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized and directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;
  import mips_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  ctrl_t       id_ctrl;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic        flush;
  logic        ex_valid;
  ctrl_t       ex_ctrl;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic        stall, en_reg;
  logic [31:0] bubble_cnt;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall(stall), .en_reg(en_reg)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

`ifndef ID_EX_PERF_EN
  assign bubble_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: what the EX stage should hold, written from the stage's rules.
  logic        m_valid;
  ctrl_t       m_ctrl;
  logic [31:0] m_pc4, m_rs_data, m_rt_data, m_imm, m_cnt;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [5:0]  m_funct;

  function automatic logic model_stall();
    logic reads_rs, reads_rt, hit;
    if (rst) return 1'b0;
    reads_rs = !id_ctrl.jump;
    reads_rt = id_ctrl.reg_dst || id_ctrl.branch || id_ctrl.mem_write;
    hit = (reads_rs && m_rt == id_rs) || (reads_rt && m_rt == id_rt);
    return m_valid && m_ctrl.mem_read && m_rt != 0 && id_valid && hit;
  endfunction

  task automatic model_edge();
    logic st;
    st = model_stall();
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_pc4 = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0; m_cnt = 0;
    end else begin
      if (st || flush || !id_valid) begin
        m_valid = 0; m_ctrl = '0;
      end else begin
        m_valid = 1; m_ctrl = id_ctrl;
      end
      m_pc4 = id_pc4; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_funct = id_funct;
      if ((st || flush) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  // Checks combinational outputs before the edge, then all registered outputs after.
  task automatic cycle();
    logic st;
    #1;
    st = model_stall();
    check("stall", stall, st);
    check("en_reg", en_reg, !st);
    @(posedge clk);
    model_edge();
    #1;
    check("ex_valid", ex_valid, m_valid);
    check("ex_ctrl", ex_ctrl, m_ctrl);
    check("ex_pc4", ex_pc4, m_pc4);
    check("ex_rs_data", ex_rs_data, m_rs_data);
    check("ex_rt_data", ex_rt_data, m_rt_data);
    check("ex_imm", ex_imm, m_imm);
    check("ex_rs", ex_rs, m_rs);
    check("ex_rt", ex_rt, m_rt);
    check("ex_rd", ex_rd, m_rd);
    check("ex_funct", ex_funct, m_funct);
`ifdef ID_EX_PERF_EN
    check("bubble_cnt", bubble_cnt, m_cnt);
`endif
  endtask

  task automatic rand_data();
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rd = 5'($urandom); id_funct = 6'($urandom);
  endtask

  task automatic set_instr(input opcode_t op, input logic [4:0] rs, input logic [4:0] rt);
    rand_data();
    id_valid = 1; flush = 0; id_ctrl = decode_ctrl(op); id_rs = rs; id_rt = rt;
  endtask

  opcode_t ops[7] = '{OP_R_FORMAT, OP_J, OP_BEQ, OP_ADDIU, OP_MADDU, OP_LW, OP_SW};
  logic [31:0] cnt0;

  initial begin
    m_valid = 0; m_ctrl = '0; m_rt = 0; m_cnt = 0;
    rst = 1; flush = $urandom; id_valid = $urandom; id_ctrl = ctrl_t'($urandom);
    id_rs = 5'($urandom); id_rt = 5'($urandom); rand_data();
    cycle();
    id_ctrl = ctrl_t'($urandom); rand_data();
    cycle();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_ex_imm", ex_imm, 0);
    check("rst_en_reg", en_reg, 1);
    rst = 0;

    // ADDIU pass-through
    set_instr(OP_ADDIU, 5'd3, 5'd8); id_imm = 32'h0000_0005;
    cycle();
    check("addiu_imm", ex_imm, 32'd5);
    check("addiu_rt", ex_rt, 8);
    check("addiu_regwrite", ex_ctrl.reg_write, 1);
    check("addiu_valid", ex_valid, 1);

    // Load-use: exactly one stall, then the R-type enters EX
    cnt0 = m_cnt;
    set_instr(OP_LW, 5'd2, 5'd8);
    cycle();
    set_instr(OP_R_FORMAT, 5'd8, 5'd3);
    #1;
    check("lu_stall", stall, 1);
    check("lu_en_reg", en_reg, 0);
    cycle();
    check("lu_bubble", ex_valid, 0);
    check("lu_stall_gone", stall, 0);
    cycle();
    check("lu_rtype_in", ex_valid, 1);
    check("lu_rtype_rs", ex_rs, 8);
`ifdef ID_EX_PERF_EN
    check("lu_cnt", bubble_cnt, cnt0 + 1);
`endif

    // No false hazards: $0 destination, and J whose rs/rt fields happen to match
    set_instr(OP_LW, 5'd1, 5'd0); cycle();
    set_instr(OP_R_FORMAT, 5'd0, 5'd0); #1; check("lw0_stall", stall, 0); cycle();
    set_instr(OP_LW, 5'd1, 5'd8); cycle();
    set_instr(OP_J, 5'd8, 5'd8); #1; check("j_stall", stall, 0); cycle();

    // Flush with BEQ, then flush and stall together
    set_instr(OP_BEQ, 5'd4, 5'd5); flush = 1; cycle();
    check("flush_valid", ex_valid, 0);
    check("flush_ctrl", ex_ctrl, 0);
    set_instr(OP_LW, 5'd1, 5'd9); cycle();
    cnt0 = m_cnt;
    set_instr(OP_SW, 5'd2, 5'd9); flush = 1;
    #1; check("fs_stall", stall, 1);
    cycle();
    check("fs_valid", ex_valid, 0);
`ifdef ID_EX_PERF_EN
    check("fs_cnt", bubble_cnt, cnt0 + 1);
`endif

    // Reset asserted in a stall cycle
    set_instr(OP_LW, 5'd1, 5'd7); cycle();
    set_instr(OP_BEQ, 5'd7, 5'd1); #1; check("pre_rst_stall", stall, 1);
    rst = 1; #1; check("rst_mask_stall", stall, 0); check("rst_mask_en", en_reg, 1);
    cycle();
    rst = 0; cycle();
    check("post_rst_valid", ex_valid, 1);

`ifdef ID_EX_PERF_EN
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    set_instr(OP_BEQ, 5'd1, 5'd2); flush = 1; cycle();
    check("sat_cnt", bubble_cnt, 32'hFFFF_FFFF);
`endif

    // Randomized traffic biased towards small register numbers to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) id_ctrl = ctrl_t'($urandom);
      else id_ctrl = decode_ctrl(ops[$urandom_range(0, 6)]);
      id_rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      id_rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      rand_data();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
